// File: rtl/pixel_arb_pkg.sv
// Shared types for the pixel arbiter: source tags, arbiter states and the FIFO entry layout.
package pixel_arb_pkg;

    localparam int unsigned COORD_W = 8;
    localparam int unsigned COLOR_W = 3;
    localparam int unsigned SRC_W   = 2;
    localparam int unsigned KEY_W   = 2 * COORD_W + COLOR_W;
    localparam int unsigned PIX_W   = KEY_W + SRC_W;

    localparam logic [SRC_W-1:0] SRC_FREE = 2'd0;
    localparam logic [SRC_W-1:0] SRC_FILL = 2'd1;
    localparam logic [SRC_W-1:0] SRC_UNDO = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FREE = 2'd1,
        ST_FILL = 2'd2,
        ST_UNDO = 2'd3
    } arb_state_t;

    typedef struct packed {
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
        logic [COLOR_W-1:0] color;
        logic [SRC_W-1:0]   src;
    } pixel_t;

    // Priority order used whenever the fill lock is not holding: undo > fill > freehand.
    function automatic arb_state_t pick_state(input logic undo_req, input logic fill_req,
                                              input logic fh_req);
        if (undo_req) return ST_UNDO;
        if (fill_req) return ST_FILL;
        if (fh_req)   return ST_FREE;
        return ST_IDLE;
    endfunction

endpackage

// File: rtl/pixel_arbiter_if.sv
// Requester, consumer and status signals of the pixel arbiter.
interface pixel_arbiter_if #(
    parameter int unsigned AW = 2
);
    logic       fh_valid;
    logic [7:0] fh_x;
    logic [7:0] fh_y;
    logic [2:0] fh_color;
    logic       fh_ready;

    logic       fill_busy;
    logic       fill_valid;
    logic [7:0] fill_x;
    logic [7:0] fill_y;
    logic [2:0] fill_color;
    logic       fill_ready;

    logic       undo_valid;
    logic [7:0] undo_x;
    logic [7:0] undo_y;
    logic [2:0] undo_color;
    logic       undo_ready;

    logic       out_valid;
    logic [7:0] out_x;
    logic [7:0] out_y;
    logic [2:0] out_color;
    logic [1:0] out_src;
    logic       out_ready;

    logic [1:0]  state;
    logic [AW:0] level;

    modport master (
        output fh_valid, fh_x, fh_y, fh_color,
        output fill_busy, fill_valid, fill_x, fill_y, fill_color,
        output undo_valid, undo_x, undo_y, undo_color,
        output out_ready,
        input  fh_ready, fill_ready, undo_ready,
        input  out_valid, out_x, out_y, out_color, out_src,
        input  state, level
    );

    modport slave (
        input  fh_valid, fh_x, fh_y, fh_color,
        input  fill_busy, fill_valid, fill_x, fill_y, fill_color,
        input  undo_valid, undo_x, undo_y, undo_color,
        input  out_ready,
        output fh_ready, fill_ready, undo_ready,
        output out_valid, out_x, out_y, out_color, out_src,
        output state, level
    );
endinterface

// File: rtl/pixel_fifo.sv
// Small pixel FIFO with a registered head entry and an occupancy count.
module pixel_fifo
    import pixel_arb_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        push,
    input  pixel_t      push_data,
    input  logic        pop,
    output pixel_t      head,
    output logic [AW:0] level,
    output logic        full
);
    localparam int unsigned LW = AW + 1;

    pixel_t        mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   level_q;
    logic          do_push;
    logic          do_pop;

    assign full    = (level_q == LW'(DEPTH));
    assign do_push = push && !full;
    assign do_pop  = pop && (level_q != '0);

    // Pointers are exactly log2(DEPTH) wide so they wrap on their own.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level_q <= '0;
            for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (do_pop) rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   level_q <= level_q + LW'(1);
                2'b01:   level_q <= level_q - LW'(1);
                default: level_q <= level_q;
            endcase
        end
    end

    assign head  = mem[rd_ptr];
    assign level = level_q;

endmodule

// File: rtl/pixel_arbiter.sv
// Fixed-priority arbiter sharing one pixel stream between freehand, fill and undo requesters.
// Define PIXEL_ARB_DEDUP_EN to coalesce repeated freehand pixels.
module pixel_arbiter
    import pixel_arb_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = 2
) (
    input  logic           clk,
    input  logic           rst_n,
    pixel_arbiter_if.slave bus
);
    arb_state_t  state_q;
    logic        full;
    logic        fh_acc;
    logic        fill_acc;
    logic        undo_acc;
    logic        fh_dup;
    logic        push;
    logic        pop;
    pixel_t      push_pix;
    pixel_t      head;
    logic [AW:0] level;

    // Fill holds the grant while busy; every other state re-arbitrates each cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else if (state_q == ST_FILL && bus.fill_busy) begin
            state_q <= ST_FILL;
        end else begin
            state_q <= pick_state(bus.undo_valid, bus.fill_busy, bus.fh_valid);
        end
    end

    assign bus.fh_ready   = (state_q == ST_FREE) && !full;
    assign bus.undo_ready = (state_q == ST_UNDO) && !full;
    assign bus.fill_ready = (state_q == ST_FILL) && bus.fill_busy && !full;

    assign fh_acc   = bus.fh_valid   && bus.fh_ready;
    assign fill_acc = bus.fill_valid && bus.fill_ready;
    assign undo_acc = bus.undo_valid && bus.undo_ready;

`ifdef PIXEL_ARB_DEDUP_EN
    logic             hist_vld;
    logic [KEY_W-1:0] hist;
    logic [KEY_W-1:0] fh_key;

    assign fh_key = {bus.fh_x, bus.fh_y, bus.fh_color};
    assign fh_dup = hist_vld && (hist == fh_key);

    // Last accepted freehand pixel; any other source breaks the run.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hist_vld <= 1'b0;
            hist     <= '0;
        end else if (fill_acc || undo_acc) begin
            hist_vld <= 1'b0;
        end else if (fh_acc) begin
            hist_vld <= 1'b1;
            hist     <= fh_key;
        end
    end
`else
    assign fh_dup = 1'b0;
`endif

    always_comb begin
        push     = 1'b0;
        push_pix = '0;
        if (undo_acc) begin
            push     = 1'b1;
            push_pix = '{x: bus.undo_x, y: bus.undo_y, color: bus.undo_color, src: SRC_UNDO};
        end else if (fill_acc) begin
            push     = 1'b1;
            push_pix = '{x: bus.fill_x, y: bus.fill_y, color: bus.fill_color, src: SRC_FILL};
        end else if (fh_acc && !fh_dup) begin
            push     = 1'b1;
            push_pix = '{x: bus.fh_x, y: bus.fh_y, color: bus.fh_color, src: SRC_FREE};
        end
    end

    assign pop = (level != '0) && bus.out_ready;

    pixel_fifo #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (push_pix),
        .pop       (pop),
        .head      (head),
        .level     (level),
        .full      (full)
    );

    assign bus.out_valid = (level != '0);
    assign bus.out_x     = head.x;
    assign bus.out_y     = head.y;
    assign bus.out_color = head.color;
    assign bus.out_src   = head.src;
    assign bus.state     = state_q;
    assign bus.level     = level;

endmodule

// File: tb/tb_pixel_arbiter.sv
// Bench for pixel_arbiter: directed scenarios plus randomized traffic against a queue-based model.
`timescale 1ns/1ps
module tb_pixel_arbiter;
    import pixel_arb_pkg::*;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned AW    = 2;
    localparam int unsigned LW    = AW + 1;
`ifdef PIXEL_ARB_DEDUP_EN
    localparam bit DEDUP = 1'b1;
`else
    localparam bit DEDUP = 1'b0;
`endif
    localparam int G_IDLE = 0, G_FREE = 1, G_FILL = 2, G_UNDO = 3;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    pixel_arbiter_if #(.AW(AW)) bus ();
    pixel_arbiter #(.DEPTH(DEPTH), .AW(AW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    // Reference model: who owns the stream, a queue of buffered pixels, last freehand pixel.
    pixel_t      m_q[$];
    int          m_grant;
    bit          m_hv;
    logic [18:0] m_hist;

    logic e_fh_r, e_fill_r, e_undo_r, e_ov;
    logic [AW:0] e_level;
    logic [1:0]  e_state;
    pixel_t      e_head;
    logic o_fh_r, o_fill_r, o_undo_r, o_ov;
    logic [AW:0] o_level;
    logic [1:0]  o_state;
    pixel_t      o_head;
    pixel_t      seen[$];
    int n_checks = 0;
    int n_fail   = 0;

    task automatic model_reset();
        m_q.delete(); m_grant = G_IDLE; m_hv = 1'b0; m_hist = '0;
    endtask

    task automatic model_update();
        logic [18:0] key;
        key = {bus.fh_x, bus.fh_y, bus.fh_color};
        if (!rst_n) begin
            model_reset();
        end else begin
            if (e_ov && bus.out_ready) void'(m_q.pop_front());
            if (bus.undo_valid && e_undo_r) begin
                m_q.push_back('{x: bus.undo_x, y: bus.undo_y, color: bus.undo_color, src: 2'd2});
                m_hv = 1'b0;
            end else if (bus.fill_valid && e_fill_r) begin
                m_q.push_back('{x: bus.fill_x, y: bus.fill_y, color: bus.fill_color, src: 2'd1});
                m_hv = 1'b0;
            end else if (bus.fh_valid && e_fh_r) begin
                if (!(DEDUP && m_hv && m_hist == key))
                    m_q.push_back('{x: bus.fh_x, y: bus.fh_y, color: bus.fh_color, src: 2'd0});
                m_hv = 1'b1; m_hist = key;
            end
            if (!(m_grant == G_FILL && bus.fill_busy)) begin
                if (bus.undo_valid)     m_grant = G_UNDO;
                else if (bus.fill_busy) m_grant = G_FILL;
                else if (bus.fh_valid)  m_grant = G_FREE;
                else                    m_grant = G_IDLE;
            end
        end
    endtask

    // One clock: expectations and observations at the falling edge, model advances at the rising edge.
    task automatic cycle();
        bit full;
        @(negedge clk);
        full     = (m_q.size() == DEPTH);
        e_fh_r   = (m_grant == G_FREE) && !full;
        e_undo_r = (m_grant == G_UNDO) && !full;
        e_fill_r = (m_grant == G_FILL) && bus.fill_busy && !full;
        e_ov     = (m_q.size() != 0);
        e_level  = LW'(m_q.size());
        e_state  = 2'(m_grant);
        e_head   = e_ov ? m_q[0] : '0;
        o_fh_r = bus.fh_ready; o_fill_r = bus.fill_ready; o_undo_r = bus.undo_ready;
        o_ov = bus.out_valid; o_level = bus.level; o_state = bus.state;
        o_head = '{x: bus.out_x, y: bus.out_y, color: bus.out_color, src: bus.out_src};
        if (o_ov === 1'b1 && bus.out_ready) seen.push_back(o_head);
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic idle_inputs();
        bus.fh_valid = 0; bus.fh_x = 0; bus.fh_y = 0; bus.fh_color = 0;
        bus.fill_busy = 0; bus.fill_valid = 0; bus.fill_x = 0; bus.fill_y = 0; bus.fill_color = 0;
        bus.undo_valid = 0; bus.undo_x = 0; bus.undo_y = 0; bus.undo_color = 0;
        bus.out_ready = 0;
    endtask

    task automatic do_reset();
        idle_inputs(); rst_n = 0; cycle(); cycle(); rst_n = 1; seen.delete();
    endtask

    task automatic test_reset();
        idle_inputs(); bus.out_ready = 1; rst_n = 0; cycle(); cycle();
        n_checks++; if (o_ov !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%b exp=0", o_ov); end
        n_checks++; if (o_level !== '0) begin n_fail++; $display("FAIL reset_level got=%0d exp=0", o_level); end
        n_checks++; if (o_state !== 2'd0) begin n_fail++; $display("FAIL reset_state got=%0d exp=0", o_state); end
        n_checks++; if ({o_fh_r, o_fill_r, o_undo_r} !== 3'b000) begin n_fail++; $display("FAIL reset_ready got=%b exp=000", {o_fh_r, o_fill_r, o_undo_r}); end
        n_checks++; if (o_head !== '0) begin n_fail++; $display("FAIL reset_head got=%h exp=0", o_head); end
        rst_n = 1;
    endtask

    task automatic test_freehand_repeat();
        int acc;
        pixel_t want;
        do_reset(); acc = 0;
        want = '{x: 8'd10, y: 8'd20, color: 3'd5, src: 2'd0};
        bus.out_ready = 1; bus.fh_valid = 1; bus.fh_x = 8'd10; bus.fh_y = 8'd20; bus.fh_color = 3'd5;
        for (int i = 0; i < 20 && acc < 5; i++) begin cycle(); if (o_fh_r === 1'b1) acc++; end
        bus.fh_valid = 0; repeat (8) cycle();
        n_checks++; if (acc !== 5) begin n_fail++; $display("FAIL fh_repeat_accepts got=%0d exp=5", acc); end
        n_checks++; if (seen.size() !== (DEDUP ? 1 : 5)) begin n_fail++; $display("FAIL fh_repeat_entries got=%0d exp=%0d", seen.size(), DEDUP ? 1 : 5); end
        for (int i = 0; i < seen.size(); i++) begin
            n_checks++; if (seen[i] !== want) begin n_fail++; $display("FAIL fh_repeat_entry%0d got=%h exp=%h", i, seen[i], want); end
        end
    endtask

    task automatic test_fill_lock();
        int k;
        do_reset(); k = 0; bus.out_ready = 1;
        bus.fh_valid = 1; bus.fh_x = 8'd7; bus.fh_y = 8'd7; bus.fh_color = 3'd1;
        bus.fill_busy = 1; bus.fill_valid = 1; bus.fill_y = 0; bus.fill_color = 3'd3;
        cycle();
        bus.undo_valid = 1; bus.undo_x = 8'd50; bus.undo_y = 8'd60; bus.undo_color = 3'd2;
        for (int i = 0; i < 20 && k < 3; i++) begin
            bus.fill_x = 8'(k); cycle();
            n_checks++; if ({o_fh_r, o_undo_r} !== 2'b00) begin n_fail++; $display("FAIL fill_lock_ready got=%b exp=00", {o_fh_r, o_undo_r}); end
            if (o_fill_r === 1'b1) k++;
        end
        bus.fill_busy = 0; bus.fill_valid = 0; repeat (4) cycle();
        bus.undo_valid = 0; bus.fh_valid = 0; repeat (8) cycle();
        n_checks++; if (seen.size() < 4) begin n_fail++; $display("FAIL fill_lock_entries got=%0d exp>=4", seen.size()); end
        else begin
            for (int i = 0; i < 3; i++) begin
                n_checks++;
                if (seen[i] !== '{x: 8'(i), y: 8'd0, color: 3'd3, src: 2'd1}) begin n_fail++; $display("FAIL fill_lock_entry%0d got=%h", i, seen[i]); end
            end
            n_checks++; if (seen[3] !== '{x: 8'd50, y: 8'd60, color: 3'd2, src: 2'd2}) begin n_fail++; $display("FAIL fill_then_undo got=%h exp src 2 (50,60,2)", seen[3]); end
        end
    endtask

    task automatic test_undo_priority();
        pixel_t fh_pix;
        do_reset(); bus.out_ready = 1;
        fh_pix = '{x: 8'd9, y: 8'd9, color: 3'd2, src: 2'd0};
        bus.undo_valid = 1; bus.undo_x = 8'd3; bus.undo_y = 8'd4; bus.undo_color = 3'd6;
        bus.fh_valid = 1; bus.fh_x = 8'd9; bus.fh_y = 8'd9; bus.fh_color = 3'd2;
        cycle(); cycle();
        n_checks++; if (o_state !== 2'd3) begin n_fail++; $display("FAIL undo_state got=%0d exp=3", o_state); end
        n_checks++; if ({o_undo_r, o_fh_r} !== 2'b10) begin n_fail++; $display("FAIL undo_ready got=%b exp=10", {o_undo_r, o_fh_r}); end
        cycle(); bus.undo_valid = 0; repeat (5) cycle();
        bus.fh_valid = 0; repeat (6) cycle();
        n_checks++; if (seen.size() < 3) begin n_fail++; $display("FAIL undo_entries got=%0d exp>=3", seen.size()); end
        else begin
            n_checks++; if (seen[0] !== '{x: 8'd3, y: 8'd4, color: 3'd6, src: 2'd2}) begin n_fail++; $display("FAIL undo_first got=%h", seen[0]); end
            n_checks++; if (seen[seen.size()-1] !== fh_pix) begin n_fail++; $display("FAIL undo_then_fh got=%h exp=%h", seen[seen.size()-1], fh_pix); end
        end
    endtask

    task automatic test_full_stall();
        int k;
        pixel_t h0;
        do_reset(); k = 0; bus.fh_valid = 1;
        h0 = '{x: 8'd100, y: 8'd0, color: 3'd0, src: 2'd0};
        for (int i = 0; i < 20 && k < 4; i++) begin
            bus.fh_x = 8'(100 + k); bus.fh_y = 8'(k); bus.fh_color = 3'(k); cycle();
            if (o_fh_r === 1'b1) k++;
        end
        bus.fh_x = 8'd104; bus.fh_y = 8'd4; bus.fh_color = 3'd4;
        for (int i = 0; i < 3; i++) begin
            cycle();
            n_checks++; if (o_level !== LW'(4) || o_fh_r !== 1'b0) begin n_fail++; $display("FAIL full_stall level=%0d fh_ready=%b exp 4/0", o_level, o_fh_r); end
            n_checks++; if (o_head !== h0) begin n_fail++; $display("FAIL full_head_stable got=%h exp=%h", o_head, h0); end
        end
        bus.out_ready = 1; cycle(); bus.out_ready = 0; cycle();
        n_checks++; if (o_level !== LW'(3) || o_fh_r !== 1'b1) begin n_fail++; $display("FAIL after_pop level=%0d fh_ready=%b exp 3/1", o_level, o_fh_r); end
        cycle();
        n_checks++; if (o_level !== LW'(4)) begin n_fail++; $display("FAIL refill_level got=%0d exp=4", o_level); end
        n_checks++; if (o_head !== '{x: 8'd101, y: 8'd1, color: 3'd1, src: 2'd0}) begin n_fail++; $display("FAIL refill_head got=%h", o_head); end
        bus.fh_valid = 0; bus.out_ready = 1; repeat (6) cycle();
    endtask

    task automatic test_reset_mid_fill();
        int k;
        do_reset(); k = 0; bus.fill_busy = 1; bus.fill_valid = 1;
        for (int i = 0; i < 20 && k < 3; i++) begin bus.fill_x = 8'(k); cycle(); if (o_fill_r === 1'b1) k++; end
        bus.fill_valid = 0; cycle();
        n_checks++; if (o_level !== LW'(3)) begin n_fail++; $display("FAIL midfill_level got=%0d exp=3", o_level); end
        rst_n = 0; cycle(); rst_n = 1;
        bus.fill_busy = 0; bus.fill_valid = 1; bus.fill_x = 8'd77; bus.fill_y = 8'd1; bus.fill_color = 3'd7;
        cycle();
        n_checks++; if (o_level !== '0 || o_ov !== 1'b0 || o_state !== 2'd0) begin n_fail++; $display("FAIL midfill_reset level=%0d valid=%b state=%0d exp 0/0/0", o_level, o_ov, o_state); end
        cycle();
        n_checks++; if (o_fill_r !== 1'b0 || o_level !== '0) begin n_fail++; $display("FAIL fill_before_busy ready=%b level=%0d exp 0/0", o_fill_r, o_level); end
        bus.fill_busy = 1; cycle();
        n_checks++; if (o_fill_r !== 1'b0) begin n_fail++; $display("FAIL fill_busy_latency got=%b exp=0", o_fill_r); end
        cycle(); bus.fill_valid = 0;
        n_checks++; if (o_fill_r !== 1'b1 || o_state !== 2'd2) begin n_fail++; $display("FAIL fill_after_busy ready=%b state=%0d exp 1/2", o_fill_r, o_state); end
        cycle();
        n_checks++; if (o_level !== LW'(1) || o_head !== '{x: 8'd77, y: 8'd1, color: 3'd7, src: 2'd1}) begin n_fail++; $display("FAIL fill_after_reset level=%0d head=%h", o_level, o_head); end
        bus.fill_busy = 0; bus.out_ready = 1; repeat (4) cycle();
    endtask

    task automatic test_fill_without_busy();
        do_reset(); bus.fill_valid = 1; bus.fill_x = 8'd5;
        repeat (4) begin
            cycle();
            n_checks++; if (o_fill_r !== 1'b0 || o_level !== '0) begin n_fail++; $display("FAIL fill_no_busy ready=%b level=%0d exp 0/0", o_fill_r, o_level); end
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(0, 9) == 0) bus.fill_busy = ~bus.fill_busy;
            bus.fh_valid   = ($urandom_range(0, 2) != 0);
            bus.fh_x       = 8'($urandom_range(0, 1));
            bus.fh_y       = 8'd3;
            bus.fh_color   = 3'($urandom_range(0, 1));
            bus.fill_valid = ($urandom_range(0, 1) != 0);
            bus.fill_x = 8'($urandom); bus.fill_y = 8'($urandom); bus.fill_color = 3'($urandom);
            bus.undo_valid = ($urandom_range(0, 5) == 0);
            bus.undo_x = 8'($urandom); bus.undo_y = 8'($urandom); bus.undo_color = 3'($urandom);
            bus.out_ready  = ($urandom_range(0, 3) != 0);
            rst_n          = ($urandom_range(0, 299) != 0);
            cycle();
            n_checks++; if ({o_fh_r, o_fill_r, o_undo_r} !== {e_fh_r, e_fill_r, e_undo_r}) begin n_fail++; $display("FAIL rand_ready cyc=%0d got=%b exp=%b", c, {o_fh_r, o_fill_r, o_undo_r}, {e_fh_r, e_fill_r, e_undo_r}); end
            n_checks++; if (o_level !== e_level || o_ov !== e_ov) begin n_fail++; $display("FAIL rand_level cyc=%0d got=%0d/%b exp=%0d/%b", c, o_level, o_ov, e_level, e_ov); end
            n_checks++; if (o_state !== e_state) begin n_fail++; $display("FAIL rand_state cyc=%0d got=%0d exp=%0d", c, o_state, e_state); end
            if (e_ov) begin
                n_checks++; if (o_head !== e_head) begin n_fail++; $display("FAIL rand_head cyc=%0d got=%h exp=%h", c, o_head, e_head); end
            end
        end
        rst_n = 1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        idle_inputs(); rst_n = 0; model_reset();
        test_reset();
        test_freehand_repeat();
        test_fill_lock();
        test_undo_priority();
        test_full_stall();
        test_reset_mid_fill();
        test_fill_without_busy();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pixel_arbiter.md
Name: pixel_arbiter

Overview:
Shares the single pixel stream feeding the I2C host readout between three requesters: freehand cursor painting, rectangle fill, and undo/redo restore.
- Grants one requester per cycle under fixed priority.
- Locks to fill for the whole fill operation.
- Coalesces repeated freehand pixels.
- Buffers accepted pixels in a small FIFO toward the I2C slave, which drains through a valid/ready handshake.

Parameters:
DEPTH, 4, output FIFO entries; power of two, minimum 2.
AW, 2, FIFO pointer width; equals log2(DEPTH).

Ports:
clk  in  1  system clock
rst_n  in  1  reset; synchronous, active-low
fh_valid  in  1  freehand pixel request (level; may repeat every cycle)
fh_x, fh_y  in  8 each  freehand coordinate
fh_color  in  3  freehand colour
fh_ready  out  1  freehand pixel accepted this cycle when high with fh_valid
fill_busy  in  1  fill engine active; drives the lock
fill_valid  in  1  fill pixel request
fill_x, fill_y  in  8 each  fill coordinate
fill_color  in  3  fill colour
fill_ready  out  1  fill accept
undo_valid  in  1  undo/redo restore pixel request
undo_x, undo_y  in  8 each  restore coordinate
undo_color  in  3  restore colour
undo_ready  out  1  undo accept
out_valid  out  1  FIFO head valid
out_x, out_y  out  8 each  head coordinate
out_color  out  3  head colour
out_src  out  2  head source: 0 freehand, 1 fill, 2 undo
out_ready  in  1  consumer pops head when high with out_valid
state  out  2  arbiter state, for status byte
level  out  AW+1  FIFO occupancy, 0..DEPTH

Behaviour:
Reset (rst_n low at a clk edge), all outputs and state:
- FIFO emptied; out_valid=0; out_x/out_y/out_color/out_src=0.
- state=IDLE; level=0; all *_ready=0; dedup history invalid.
- Reset mid-fill or mid-drain discards all buffered pixels; no partial output afterwards.

States (encoding): IDLE=0, FREE=1, FILL=2, UNDO=3.
- IDLE: undo_valid -> UNDO; else fill_busy -> FILL; else fh_valid -> FREE.
- FREE: undo_valid -> UNDO; fill_busy -> FILL; !fh_valid -> IDLE.
- UNDO: stays while undo_valid; then -> FILL if fill_busy, -> FREE if fh_valid, else -> IDLE.
- FILL: only fill is served. Undo and freehand held off (ready=0) until fill_busy falls; then next state is chosen as from IDLE.
- Transitions take effect the cycle after the deciding inputs. The grant for cycle N is a function of the state registered at edge N.

Ready and accept:
- ready(granted requester) = !full; all other readies = 0.
- Accept = valid && ready. The accepted pixel is written into the FIFO at that same edge with its out_src tag.
- One push per cycle maximum.

Freehand dedup:
- When PIXEL_ARB_DEDUP_EN is defined, a freehand pixel equal to the last accepted freehand {x,y,color} is acknowledged (fh_ready=1) but not pushed.
- History is invalidated by reset and by any fill or undo accept.

FIFO:
- Registered head; out_valid = level!=0; pop = out_valid && out_ready.
- Push and pop in the same cycle: level unchanged; legal when full because ready is computed from the registered full flag, so no push occurs that cycle when full.
- Pointers wrap modulo DEPTH.
- Latency: an accepted pixel appears on out_* at the next edge if the FIFO was empty.
- Head data is stable while out_valid && !out_ready.

Priority on simultaneous requests:
- Outside FILL: undo > fill > freehand.
- fill_valid without fill_busy is ignored (fill_ready=0).

Optional Feature:
PIXEL_ARB_DEDUP_EN:
- Defined: freehand coalescing as above; adds the 19-bit history register.
- Undefined: every accepted freehand pixel is pushed; no history register.

Decomposition:
- Shared package pixel_arb_pkg holds: source codes SRC_FREE=0, SRC_FILL=1, SRC_UNDO=2; state encodings; pixel entry width 21 (8+8+3+2).
- One sub-module: pixel_fifo (DEPTH-parameterised, registered head, level output). The arbiter FSM and dedup stay in the top.

Test Plan:
- Reset, then fh_valid=1 at (10,20,col 5) held 5 cycles, out_ready=1. Dedup on: exactly one entry (10,20,5,src 0). Dedup off: 5 entries.
- fill_busy rises with fill pixels (0,0),(1,0),(2,0) while fh_valid=1 and undo_valid=1 -> three src 1 entries in order; undo_ready and fh_ready stay 0 until fill_busy falls; next entry is src 2.
- undo_valid and fh_valid asserted in the same cycle from IDLE -> first push is undo; state=3; freehand accepted only after undo_valid drops.
- out_ready=0, 4 distinct freehand pixels -> level=4, fh_ready=0 on the 5th; one pop cycle then push -> level stays 4; head values unchanged while stalled.
- Reset asserted with level=3 mid-fill -> next cycle level=0, out_valid=0, state=0; fill pixels after release are accepted only once fill_busy is seen again.
- fill_valid=1 with fill_busy=0 -> fill_ready=0, nothing pushed, level stays 0.
